idma_axi_read_responder: RTL
============================

# idma_axi_read_responder

AXI4 read responder (subordinate) that serves the INCR read bursts emitted by the iDMA read legalizer and AR channel. It accepts one AR burst at a time, checks its legality, fetches each beat from an in-order request/grant memory port, and returns the R beats with correct ID, response and `last`. It sits at the far end of the iDMA read path, standing in for on-chip memory in subsystem benches and small SoC tiles.

## Interface
- `DataWidth`, 32: data bus width in bits; StrbWidth = DataWidth/8, OffsetWidth = log2(StrbWidth).
- `AddrWidth`, 24: address width in bits.
- `IdWidth`, 4: AXI ID width.
- `BufDepth`, 4: response buffer depth in beats, at least 2; bounds outstanding memory reads.

- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `ar_id_i`, `ar_addr_i`, `ar_len_i`, `ar_size_i`, `ar_burst_i` in IdWidth/AddrWidth/8/3/2: AR payload.
- `ar_valid_i` in 1, `ar_ready_o` out 1: AR handshake.
- `r_id_o` out IdWidth, `r_data_o` out DataWidth, `r_resp_o` out 2, `r_last_o` out 1: R payload.
- `r_valid_o` out 1, `r_ready_i` in 1: R handshake.
- `mem_req_o` out 1, `mem_gnt_i` in 1, `mem_addr_o` out AddrWidth: memory read request; the request transfers when both `mem_req_o` and `mem_gnt_i` are high.
- `mem_rvalid_i` in 1, `mem_rdata_i` in DataWidth, `mem_err_i` in 1: in-order memory response, at least 1 cycle after grant. It has no backpressure.
- `busy_o` out 1: a burst is active or responses are pending.

## Operation
- States:
  - IDLE: `ar_ready_o`=1. On the AR handshake, latch the ID, the address, and beats = len+1 (9-bit counter). Go to READ if legal, else ERR.
- Legal burst, all of the following must hold:
  - burst = INCR;
  - size = OffsetWidth;
  - `ar_addr_i[OffsetWidth-1:0]` = 0;
  - addr[11:0] + beats·StrbWidth ≤ 4096, evaluated 13 bits wide with no wrap.
- READ:
  - Issue memory requests at the latched address. The address increments by StrbWidth per grant and wraps modulo 2^AddrWidth.
  - `mem_req_o` = (requests issued < beats) && (inflight + fifo_count < BufDepth). Inflight means granted but not yet returned.
  - Each `mem_rvalid_i` pushes {rdata, err} into the FIFO. The credit rule guarantees the FIFO is never full on a push.
  - The FIFO head drives R: `r_resp_o` = SLVERR (2'b10) if err, else OKAY. `r_last_o` = 1 on beat index beats-1.
  - The burst ends on the handshake of the last beat, then the block returns to IDLE.
- ERR:
  - No memory requests are issued.
  - Emit `beats` R beats with data 0 and resp SLVERR; `r_last_o` is set on the final beat.
  - Return to IDLE after the last handshake.
- `r_id_o` = latched ID for every beat.
- R payload holds stable while `r_valid_o` is high and `r_ready_i` is low.
- `busy_o` = state ≠ IDLE or inflight ≠ 0.
- Simultaneous push and pop in the same cycle leaves the FIFO count unchanged. A grant and a return in the same cycle leave inflight unchanged.

## Timing
- Reset is sampled at the clock edge. While `rst_i` is high:
  - `ar_ready_o`, `r_valid_o`, `mem_req_o`, `busy_o` = 0;
  - `r_last_o` = 0, `r_resp_o` = 0, `r_data_o` = 0, `r_id_o` = 0.
- The first cycle after reset deasserts is IDLE, with `ar_ready_o`=1.
- Reset mid-burst drops the burst, the FIFO and all counters. The memory must be reset in the same cycle; `mem_rvalid_i` is ignored while in IDLE with inflight = 0.
- A grant in the same cycle as `mem_req_o` is allowed.
- AR handshake at cycle 0:
  - `mem_req_o` rises at cycle 1;
  - with grant at 1 and `mem_rvalid_i` at 2, `r_valid_o` rises at 3 (the FIFO output is registered).
- Throughput is one beat per cycle once the pipeline fills, given BufDepth ≥ 3, a 1-cycle memory, and `r_ready_i` held high.
- ERR: first R beat at cycle 1, then one beat per cycle.
- `ar_ready_o` returns to 1 in the cycle after the last R handshake. Back-to-back bursts have a 1-cycle bubble.

## Test plan
- Legal burst: addr 0x100, len 3, size 2 (DataWidth 32), 1-cycle memory, `r_ready_i`=1. Expect memory addresses 0x100, 0x104, 0x108, 0x10C; 4 OKAY beats with matching data; last only on beat 3; first `r_valid_o` at cycle 3.
- Backpressure: len 7, `r_ready_i` low for 10 cycles. Expect at most BufDepth=4 reads outstanding or buffered; R payload stable while stalled; all 8 beats delivered in order.
- Illegal bursts:
  - FIXED burst, len 1: expect 2 SLVERR beats with zero data and no `mem_req_o`.
  - addr 0xFF8, len 3 (crosses 4 KiB): expect 4 SLVERR beats.
  - misaligned addr 0x102: expect SLVERR.
- Memory error: `mem_err_i`=1 on beat 1 of a len-2 burst. Expect resp OKAY, SLVERR, OKAY; last on beat 2.
- Reset: assert `rst_i` mid-way through a len-15 burst. Expect all outputs 0 that cycle, `ar_ready_o`=1 the next cycle, and a following len-0 burst served correctly with `r_last_o`=1.

Source files
------------

// File: rtl/idma_axi_read_responder.sv
// AXI4 read subordinate serving one INCR burst at a time from an in-order req/gnt memory; first R beat 3 cycles
// after AR (1-cycle memory), SLVERR bursts from cycle 1; R stalls hold the head beat, memory requests are credit-limited.
module idma_axi_read_responder #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned AddrWidth = 24,
   parameter int unsigned IdWidth   = 4,
   parameter int unsigned BufDepth  = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [IdWidth-1:0]   ar_id_i,
   input  logic [AddrWidth-1:0] ar_addr_i,
   input  logic [7:0]           ar_len_i,
   input  logic [2:0]           ar_size_i,
   input  logic [1:0]           ar_burst_i,
   input  logic                 ar_valid_i,
   output logic                 ar_ready_o,
   output logic [IdWidth-1:0]   r_id_o,
   output logic [DataWidth-1:0] r_data_o,
   output logic [1:0]           r_resp_o,
   output logic                 r_last_o,
   output logic                 r_valid_o,
   input  logic                 r_ready_i,
   output logic                 mem_req_o,
   input  logic                 mem_gnt_i,
   output logic [AddrWidth-1:0] mem_addr_o,
   input  logic                 mem_rvalid_i,
   input  logic [DataWidth-1:0] mem_rdata_i,
   input  logic                 mem_err_i,
   output logic                 busy_o
);
   localparam int unsigned StrbWidth   = DataWidth / 8;
   localparam int unsigned OffsetWidth = $clog2(StrbWidth);
   localparam int unsigned PtrWidth    = (BufDepth > 1) ? $clog2(BufDepth) : 1;
   localparam int unsigned CntWidth    = $clog2(BufDepth + 1);
   localparam logic [CntWidth:0] Credits    = (CntWidth + 1)'(BufDepth);
   localparam logic [1:0]        RespOkay   = 2'b00;
   localparam logic [1:0]        RespSlvErr = 2'b10;
   localparam logic [1:0]        BurstIncr  = 2'b01;

   typedef enum logic [1:0] {IDLE, READ, ERR} state_e;

   typedef struct packed {
      logic                 err;
      logic [DataWidth-1:0] data;
   } beat_t;

   state_e               state_q;
   logic [IdWidth-1:0]   id_q;
   logic [AddrWidth-1:0] addr_q;
   logic [8:0]           beats_q, req_cnt_q, beat_cnt_q;
   logic [CntWidth-1:0]  inflight_q, fifo_cnt_q;
   logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
   beat_t                buf_q [BufDepth];

   logic [8:0]        ar_beats;
   logic [31:0]       ar_end;
   logic [CntWidth:0] credit_used;
   logic              ar_legal, ar_hs, r_hs, last_beat, grant, push, pop, head_vld;

   assign ar_beats = {1'b0, ar_len_i} + 9'd1;
   // 4 KiB check done wide so a burst ending past the page can never alias back below it
   assign ar_end   = 32'(ar_addr_i[11:0]) + (32'(ar_beats) << OffsetWidth);
   assign ar_legal = (ar_burst_i == BurstIncr) && (ar_size_i == 3'(OffsetWidth))
                  && (ar_addr_i[OffsetWidth-1:0] == '0) && (ar_end <= 32'd4096);

   assign ar_hs       = ar_ready_o && ar_valid_i;
   assign r_hs        = r_valid_o && r_ready_i;
   assign head_vld    = (state_q == READ) && (fifo_cnt_q != '0);
   assign last_beat   = (beat_cnt_q == beats_q - 9'd1);
   assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
   assign grant       = mem_req_o && mem_gnt_i;
   assign push        = mem_rvalid_i && (inflight_q != '0);
   assign pop         = r_hs && (state_q == READ);

   assign ar_ready_o = !rst_i && (state_q == IDLE);
   assign mem_req_o  = !rst_i && (state_q == READ) && (req_cnt_q < beats_q) && (credit_used < Credits);
   assign mem_addr_o = addr_q;
   assign r_valid_o  = !rst_i && (head_vld || (state_q == ERR));
   assign r_id_o     = rst_i ? '0 : id_q;
   assign r_data_o   = (!rst_i && head_vld) ? buf_q[rd_ptr_q].data : '0;
   assign r_resp_o   = !r_valid_o ? RespOkay :
                       ((state_q == ERR) || buf_q[rd_ptr_q].err) ? RespSlvErr : RespOkay;
   assign r_last_o   = r_valid_o && last_beat;
   assign busy_o     = !rst_i && ((state_q != IDLE) || (inflight_q != '0));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         id_q       <= '0;
         addr_q     <= '0;
         beats_q    <= '0;
         req_cnt_q  <= '0;
         beat_cnt_q <= '0;
         inflight_q <= '0;
         fifo_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         case (state_q)
            IDLE: if (ar_hs) begin
               id_q       <= ar_id_i;
               addr_q     <= ar_addr_i;
               beats_q    <= ar_beats;
               req_cnt_q  <= '0;
               beat_cnt_q <= '0;
               state_q    <= ar_legal ? READ : ERR;
            end
            READ, ERR: if (r_hs) begin
               beat_cnt_q <= beat_cnt_q + 9'd1;
               if (last_beat) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase

         if (grant) begin
            addr_q    <= addr_q + AddrWidth'(StrbWidth);
            req_cnt_q <= req_cnt_q + 9'd1;
         end

         case ({grant, push})
            2'b10:   inflight_q <= inflight_q + CntWidth'(1);
            2'b01:   inflight_q <= inflight_q - CntWidth'(1);
            default: inflight_q <= inflight_q;
         endcase

         case ({push, pop})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + CntWidth'(1);
            2'b01:   fifo_cnt_q <= fifo_cnt_q - CntWidth'(1);
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase

         if (push) wr_ptr_q <= (wr_ptr_q == PtrWidth'(BufDepth - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
         if (pop)  rd_ptr_q <= (rd_ptr_q == PtrWidth'(BufDepth - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
      end
   end

   // Storage needs no reset: occupancy is tracked by fifo_cnt_q
   always_ff @(posedge clk_i) begin
      if (push) buf_q[wr_ptr_q] <= {mem_err_i, mem_rdata_i};
   end

endmodule
